// File: rtl/ram_sdp_if.sv
// Bus bundle for the simple-dual-port data RAM: one read port, one write
// port, the clear request and the status outputs.
interface ram_sdp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              clr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rd_valid;
  logic              ready;
  logic              err;

  // Requester side (CPU / load-store unit)
  modport master (
    output clr, rd_en, rd_addr, we, wr_addr, din,
    input  dout, rd_valid, ready, err
  );

  // Memory side
  modport slave (
    input  clr, rd_en, rd_addr, we, wr_addr, din,
    output dout, rd_valid, ready, err
  );
endinterface

// File: rtl/ram_sdp.sv
// Simple-dual-port data RAM with a sequential clear engine.
// After reset (or a clr request) every word is swept to INIT_VAL, one word
// per clock; ready is low during the sweep and accesses raise err.
// Reads are registered (one cycle latency) with a rd_valid pulse.
module ram_sdp #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 4,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0,
  parameter int                 WR_FIRST = 0
) (
  input  logic     clk,
  input  logic     areset,
  ram_sdp_if.slave bus
);
  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] clr_cnt_q,  clr_cnt_d;
  logic              ready_q,    ready_d;
  logic [DATA_W-1:0] dout_q,     dout_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q,      err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  // Next-state, write-port steering and read-data selection
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    ready_d    = ready_q;
    dout_d     = dout_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = clr_cnt_q;
    mem_wdata  = INIT_VAL;

    case (state_q)
      ST_CLEAR: begin
        // Sweep one word per edge; requests are dropped but flagged.
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        err_d     = bus.rd_en | bus.we;
        if (clr_cnt_q == LAST) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      default: begin
        if (bus.clr) begin
          // A clear request wins over any access in the same cycle.
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          ready_d   = 1'b0;
        end else begin
          if (bus.we) begin
            mem_we    = 1'b1;
            mem_waddr = bus.wr_addr;
            mem_wdata = bus.din;
          end
          if (bus.rd_en) begin
            rd_valid_d = 1'b1;
            // Collision bypass only when write-first is selected.
            if ((WR_FIRST != 0) && bus.we && (bus.wr_addr == bus.rd_addr))
              dout_d = bus.din;
            else
              dout_d = mem[bus.rd_addr];
          end
        end
      end
    endcase
  end

  // Control/output registers; reset restarts the sweep from address 0
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      ready_q    <= 1'b0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      ready_q    <= ready_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Storage write port; memory is left untouched on the reset edge
  always_ff @(posedge clk) begin
    if (!areset && mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  assign bus.dout     = dout_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;
endmodule

// File: doc/ram_sdp.md
Name: ram_sdp

Overview:
- Parametrised simple-dual-port data RAM for the mini-CPU: one read port and one write port, each usable every cycle.
- On reset, or on request, a sequential clear engine sweeps every word to INIT_VAL; `ready` reports when the memory is usable.
- Same-address read/write collision policy is selectable; reads are registered, with a valid flag.
- Sits between the CPU datapath and its load/store unit.

Parameters:
- DATA_W, 8: word width in bits.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W words.
- INIT_VAL, 0: value written to every word by the clear engine (DATA_W bits).
- WR_FIRST, 0: same-address collision policy; 1 = read returns new `din`, 0 = read returns old contents.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- areset  in  1  synchronous, active-high reset.
- clr  in  1  request a full memory clear; sampled only when ready=1.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- we  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- din  in  DATA_W  write data.
- dout  out  DATA_W  registered read data.
- rd_valid  out  1  dout updated by a read this cycle (one-cycle pulse per accepted read).
- ready  out  1  memory usable; low while clearing.
- err  out  1  one-cycle pulse: rd_en or we asserted while ready=0.

Behaviour:
- Reset is synchronous. The single clock and active-high synchronous reset (`clk`, `areset`) are fixed.
- areset=1 at an edge: state<=CLEAR, clr_cnt<=0, ready<=0, dout<=0, rd_valid<=0, err<=0. Memory contents are not touched on the reset edge itself.
- Two states: CLEAR and RUN.
- CLEAR:
  - each edge writes mem[clr_cnt]<=INIT_VAL and increments clr_cnt.
  - At the edge where clr_cnt==DEPTH-1: write the last word, state<=RUN, ready<=1.
  - Clear therefore takes exactly DEPTH edges; ready is seen high after the DEPTH-th edge following reset release.
- In CLEAR:
  - rd_en/we/clr are ignored, with no memory or dout change.
  - rd_en or we sets err<=1 for one cycle. clr does not set err.
  - dout holds its value; rd_valid=0.
- RUN, clr=1:
  - state<=CLEAR, clr_cnt<=0, ready<=0.
  - A we or rd_en in the same cycle is dropped: no write, rd_valid=0, err=0.
- RUN, clr=0:
  - we=1: mem[wr_addr]<=din at the edge.
  - rd_en=1: dout<=mem[rd_addr], rd_valid<=1 at the edge. Latency 1 cycle.
  - rd_en=0: dout holds, rd_valid<=0.
- Collision (RUN, rd_en & we & rd_addr==wr_addr):
  - WR_FIRST=1: dout<=din.
  - WR_FIRST=0: dout<=previous mem contents.
  - The write always completes.
- Different addresses: both operations complete independently in the same cycle.
- areset mid-clear: restarts the sweep at address 0 (clr_cnt<=0); ready stays 0.
- areset has priority over every other input.
- clr_cnt is ADDR_W bits; the RUN transition is on the compare, never on counter wrap.
- err is combinationally independent of data; it is registered and valid one cycle after the offending request.

Test Plan:
- Reset then clear (DATA_W=8, ADDR_W=4, INIT_VAL=8'hA5): hold areset 2 cycles, release.
  - Required: ready=0 for 16 edges, then 1.
  - Reading addresses 0..15 returns 8'hA5, with rd_valid pulsing one cycle after each rd_en.
- Write/read: write 8'h3C to addr 7, then rd_en addr 7 next cycle.
  - Required: dout=8'h3C, rd_valid=1 one cycle later; other addresses still 8'hA5.
- Collision: mem[4]=8'h11; same cycle we=1 wr_addr=4 din=8'h22, rd_en=1 rd_addr=4.
  - WR_FIRST=0 gives dout=8'h11; WR_FIRST=1 gives dout=8'h22.
  - A following read of addr 4 returns 8'h22 in both cases.
- clr in RUN with simultaneous we to addr 2 (din=8'hFF):
  - Required: ready drops next cycle, 16-edge sweep, err stays 0.
  - Afterwards addr 2 reads INIT_VAL, not 8'hFF.
- Access while clearing: assert rd_en and we during CLEAR.
  - Required: err pulses 1 cycle later, no write occurs, dout unchanged, rd_valid=0.
- Reset mid-clear: assert areset 1 cycle at clear step 9, release.
  - Required: ready low for a full 16 further edges from release, then all words read INIT_VAL.
